// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with a ready/valid handshake, synchronous flush,
// an optional two-entry skid buffer (registered in_ready) and a saturating bubble counter.
module pipe_stage_reg #(
   parameter int CTRL_W = 10,
   parameter int DATA_W = 143,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // FULL holds one entry in main; SKID additionally holds the younger entry in the skid slot.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic                m_v, s_v;
   logic                in_fire, out_fire;
   logic                ld_main_in, ld_main_skid, ld_skid;
   logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
   logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
   logic [DATA_W-1:0]   s_data_q, s_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign m_v = (state_q != ST_EMPTY);
   assign s_v = (state_q == ST_SKID);

   // With the skid buffer, in_ready depends only on stored state; without it, it looks through to out_ready.
   assign in_ready = (SKID ? !s_v : (!m_v || out_ready)) && !reset;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = m_v && out_ready;

   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d    = ST_FULL;
               ld_main_in = 1'b1;
            end
         end
         ST_FULL: begin
            if (in_fire && out_fire) begin
               ld_main_in = 1'b1;
            end else if (in_fire) begin
               state_d = ST_SKID;
               ld_skid = 1'b1;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (out_fire) begin
               state_d      = ST_FULL;
               ld_main_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush squashes everything still held plus anything accepted this cycle.
      if (flush) begin
         state_d      = ST_EMPTY;
         ld_main_in   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   always_comb begin
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      if (ld_main_in) begin
         m_ctrl_d = in_ctrl;
         m_data_d = in_data;
      end else if (ld_main_skid) begin
         m_ctrl_d = s_ctrl_q;
         m_data_d = s_data_q;
      end
      s_ctrl_d = ld_skid ? in_ctrl : s_ctrl_q;
      s_data_d = ld_skid ? in_data : s_data_q;
      cnt_d    = (out_ready && !m_v) ? sat_inc(cnt_q) : cnt_q;
   end

   // Stage boundary: main entry, state and counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_EMPTY;
         cnt_q    <= '0;
         m_ctrl_q <= '0;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         m_ctrl_q <= m_ctrl_d;
         m_data_q <= m_data_d;
      end
   end

   // Stage boundary: skid entry, only meaningful while s_v is set
   always_ff @(posedge clk) begin
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
   end

   assign out_valid  = m_v;
   assign out_ctrl   = m_ctrl_q & {CTRL_W{m_v}};
   assign out_data   = m_data_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences and a queue-based random reference.
module tb_pipe_stage_reg;
   localparam int CW = 10;
   localparam int DW = 143;
   localparam int NA = 4;
   localparam int NB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          a_reset, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [CW-1:0] a_in_ctrl, a_out_ctrl;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [NA-1:0] a_bubble_cnt;
   logic          b_reset, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [CW-1:0] b_in_ctrl, b_out_ctrl;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [NB-1:0] b_bubble_cnt;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(NA)) u_skid (
      .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .bubble_cnt(a_bubble_cnt));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(NB)) u_noskid (
      .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .bubble_cnt(b_bubble_cnt));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // f = {reset, in_valid, out_ready, flush}
   task automatic drive_a(input logic [3:0] f, input logic [CW-1:0] c, input logic [DW-1:0] d);
      {a_reset, a_in_valid, a_out_ready, a_flush} = f;
      a_in_ctrl = c;
      a_in_data = d;
   endtask

   task automatic drive_b(input logic [3:0] f, input logic [CW-1:0] c, input logic [DW-1:0] d);
      {b_reset, b_in_valid, b_out_ready, b_flush} = f;
      b_in_ctrl = c;
      b_in_data = d;
   endtask

   // e = {in_ready before the edge, out_valid after the edge}
   typedef struct {
      logic [3:0]    f;
      logic [15:0]   d;
      logic [1:0]    e;
      logic [CW-1:0] e_ctrl;
      logic [15:0]   e_d;
      logic [NA-1:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] f, input logic [15:0] d, input logic [1:0] e,
                               input logic [CW-1:0] ec, input logic [15:0] ed, input logic [NA-1:0] ecnt);
      vec_t v;
      v.f = f; v.d = d; v.e = e; v.e_ctrl = ec; v.e_d = ed; v.e_cnt = ecnt;
      return v;
   endfunction

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   vec_t          tv[$];
   ent_t          qa[$], qb[$];
   ent_t          ea, eb;
   logic [DW-1:0] mda, mdb;
   logic [NA-1:0] ca;
   logic [NB-1:0] cb;
   logic [159:0]  r;
   bit            ra, rb, ira, irb, ifa, ofa, ifb, ofb;
   int            xfer, exp_sat;
   logic [2:0]    ordy_pat;
   logic [47:0]   dat_pat;
   logic [47:0]   odat_pat;

   initial begin
      drive_a(4'b1000, '0, '0);
      drive_b(4'b1000, '0, '0);

      // reset, stream, bubbles, backpressure, flush, reset mid-stream (SKID=1, CNT_W=4)
      tv.push_back(mk(4'b1000, 16'h0,  2'b00, 10'h000, 16'h0,  4'd0));
      tv.push_back(mk(4'b1000, 16'h0,  2'b00, 10'h000, 16'h0,  4'd0));
      tv.push_back(mk(4'b0100, 16'h1,  2'b11, 10'h155, 16'h1,  4'd0));
      tv.push_back(mk(4'b0110, 16'h2,  2'b11, 10'h155, 16'h2,  4'd0));
      tv.push_back(mk(4'b0110, 16'h3,  2'b11, 10'h155, 16'h3,  4'd0));
      tv.push_back(mk(4'b0010, 16'h0,  2'b10, 10'h000, 16'h3,  4'd0));
      tv.push_back(mk(4'b0010, 16'h0,  2'b10, 10'h000, 16'h3,  4'd1));
      tv.push_back(mk(4'b0010, 16'h0,  2'b10, 10'h000, 16'h3,  4'd2));
      tv.push_back(mk(4'b0100, 16'hA,  2'b11, 10'h155, 16'hA,  4'd2));
      tv.push_back(mk(4'b0100, 16'hB,  2'b11, 10'h155, 16'hA,  4'd2));
      tv.push_back(mk(4'b0100, 16'hC,  2'b01, 10'h155, 16'hA,  4'd2));
      tv.push_back(mk(4'b0110, 16'hC,  2'b01, 10'h155, 16'hB,  4'd2));
      tv.push_back(mk(4'b0110, 16'hC,  2'b11, 10'h155, 16'hC,  4'd2));
      tv.push_back(mk(4'b0010, 16'h0,  2'b10, 10'h000, 16'hC,  4'd2));
      tv.push_back(mk(4'b0100, 16'h1A, 2'b11, 10'h155, 16'h1A, 4'd2));
      tv.push_back(mk(4'b0100, 16'h1B, 2'b11, 10'h155, 16'h1A, 4'd2));
      tv.push_back(mk(4'b0111, 16'h1C, 2'b00, 10'h000, 16'h1A, 4'd2));
      tv.push_back(mk(4'b0010, 16'h0,  2'b10, 10'h000, 16'h1A, 4'd3));
      tv.push_back(mk(4'b0100, 16'h2A, 2'b11, 10'h155, 16'h2A, 4'd3));
      tv.push_back(mk(4'b0100, 16'h2B, 2'b11, 10'h155, 16'h2A, 4'd3));
      tv.push_back(mk(4'b1100, 16'h2C, 2'b00, 10'h000, 16'h0,  4'd0));
      tv.push_back(mk(4'b0000, 16'h0,  2'b10, 10'h000, 16'h0,  4'd0));
      tv.push_back(mk(4'b0000, 16'h0,  2'b10, 10'h000, 16'h0,  4'd0));

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         drive_a(tv[i].f, tv[i].f[2] ? 10'h155 : 10'h3ff, DW'(tv[i].d));
         #1;
         chk($sformatf("t%0d in_ready", i), DW'(a_in_ready), DW'(tv[i].e[1]));
         @(posedge clk);
         #1;
         chk($sformatf("t%0d out_valid", i), DW'(a_out_valid), DW'(tv[i].e[0]));
         chk($sformatf("t%0d out_ctrl", i), DW'(a_out_ctrl), DW'(tv[i].e_ctrl));
         chk($sformatf("t%0d out_data", i), a_out_data, DW'(tv[i].e_d));
         chk($sformatf("t%0d bubble_cnt", i), DW'(a_bubble_cnt), DW'(tv[i].e_cnt));
      end

      // Idle cycles with out_ready high: counter climbs by one each and sticks at 15.
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         drive_a(4'b0010, '0, '0);
         @(posedge clk);
         #1;
         exp_sat = (k > 15) ? 15 : k;
         chk($sformatf("sat%0d bubble_cnt", k), DW'(a_bubble_cnt), DW'(exp_sat));
      end
      chk("sat out_ctrl", DW'(a_out_ctrl), '0);

      // SKID=0: fill, then out_ready 1,0,1 with in_valid held; in_ready tracks out_ready.
      @(negedge clk);
      drive_a(4'b1000, '0, '0);
      drive_b(4'b0100, 10'h155, DW'(1));
      #1;
      chk("b fill in_ready", DW'(b_in_ready), DW'(1'b1));
      @(posedge clk);
      #1;
      chk("b fill out_data", b_out_data, DW'(1));
      ordy_pat = 3'b101;
      dat_pat  = {16'd3, 16'd3, 16'd2};
      odat_pat = {16'd3, 16'd2, 16'd2};
      xfer = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_b({1'b0, 1'b1, ordy_pat[k], 1'b0}, 10'h155, DW'(dat_pat[16*k +: 16]));
         #1;
         chk($sformatf("b%0d in_ready", k), DW'(b_in_ready), DW'(ordy_pat[k]));
         if (b_in_valid && b_in_ready) xfer++;
         @(posedge clk);
         #1;
         chk($sformatf("b%0d out_data", k), b_out_data, DW'(odat_pat[16*k +: 16]));
         chk($sformatf("b%0d out_ctrl", k), DW'(b_out_ctrl), DW'(10'h155));
      end
      chk("b transfers", DW'(xfer), DW'(2));
      chk("b bubble_cnt", DW'(b_bubble_cnt), '0);

      // Random traffic against a queue model: FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
      mda = '0; mdb = '0; ca = '0; cb = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         ra = (cyc == 0) || ($urandom_range(0, 299) == 0);
         rb = (cyc == 0) || ($urandom_range(0, 299) == 0);
         r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         a_reset     = ra;
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_out_ready = ($urandom_range(0, 2) != 0);
         a_flush     = ($urandom_range(0, 19) == 0);
         a_in_ctrl   = CW'($urandom());
         a_in_data   = r[DW-1:0];
         r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         b_reset     = rb;
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_out_ready = ($urandom_range(0, 2) != 0);
         b_flush     = ($urandom_range(0, 19) == 0);
         b_in_ctrl   = CW'($urandom());
         b_in_data   = r[DW-1:0];
         #1;
         ira = !ra && (qa.size() < 2);
         irb = !rb && ((qb.size() == 0) || b_out_ready);
         chk("rnd a in_ready", DW'(a_in_ready), DW'(ira));
         chk("rnd b in_ready", DW'(b_in_ready), DW'(irb));
         ifa = a_in_valid && ira;
         ofa = (qa.size() > 0) && a_out_ready;
         ifb = b_in_valid && irb;
         ofb = (qb.size() > 0) && b_out_ready;
         ea.c = a_in_ctrl; ea.d = a_in_data;
         eb.c = b_in_ctrl; eb.d = b_in_data;
         if (ra) begin
            qa.delete(); mda = '0; ca = '0;
         end else begin
            if (a_out_ready && (qa.size() == 0) && (ca != '1)) ca = ca + 1'b1;
            if (a_flush) qa.delete();
            else begin
               if (ofa) void'(qa.pop_front());
               if (ifa) qa.push_back(ea);
            end
            if (qa.size() > 0) mda = qa[0].d;
         end
         if (rb) begin
            qb.delete(); mdb = '0; cb = '0;
         end else begin
            if (b_out_ready && (qb.size() == 0) && (cb != '1)) cb = cb + 1'b1;
            if (b_flush) qb.delete();
            else begin
               if (ofb) void'(qb.pop_front());
               if (ifb) qb.push_back(eb);
            end
            if (qb.size() > 0) mdb = qb[0].d;
         end
         @(posedge clk);
         #1;
         chk("rnd a out_valid", DW'(a_out_valid), DW'(qa.size() > 0));
         chk("rnd a out_ctrl", DW'(a_out_ctrl), DW'((qa.size() > 0) ? qa[0].c : '0));
         chk("rnd a out_data", a_out_data, mda);
         chk("rnd a bubble_cnt", DW'(a_bubble_cnt), DW'(ca));
         chk("rnd b out_valid", DW'(b_out_valid), DW'(qb.size() > 0));
         chk("rnd b out_ctrl", DW'(b_out_ctrl), DW'((qb.size() > 0) ? qb[0].c : '0));
         chk("rnd b out_data", b_out_data, mdb);
         chk("rnd b bubble_cnt", DW'(b_bubble_cnt), DW'(cb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
